mem_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between two requesters: port 0 (instruction fetch, read-only) and port 1 (data load/store).
- Serialises accesses, models a configurable multi-cycle memory latency and returns read data with a one-cycle done pulse.
- Sits between the multi-cycle CPU control/datapath and the Memory block, and drives that block's addr/din/mem_read/mem_write.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported unified memory: port 0 fetches, port 1 loads/stores.
// Optional macro MEM_ARB_RR_EN switches tie-breaking from fixed port-1 priority to round-robin.
module mem_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_0,
    input  logic [31:0] addr_0,
    output logic        done_0,
    output logic [31:0] rdata_0,

    input  logic        req_1,
    input  logic        we_1,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_1,
    output logic        done_1,
    output logic [31:0] rdata_1,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic             owner_q;
    logic [31:0]      rdata_q;
`ifdef MEM_ARB_RR_EN
    logic             last_owner_q;
`endif

    logic             mem_read_q;
    logic             mem_write_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_din_q;
    logic             done_0_q;
    logic             done_1_q;
    logic             busy_q;

    logic             grant_1_d;
    logic [31:0]      addr_d;
    logic [31:0]      wdata_d;
    logic             we_d;

    // Winner selection and the operands that get latched if a grant happens this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_1_d = req_1;
`ifdef MEM_ARB_RR_EN
        if (req_0 && req_1) begin
            grant_1_d = ~last_owner_q;
        end
`endif
        addr_d  = grant_1_d ? addr_1 : addr_0;
        wdata_d = grant_1_d ? wdata_1 : 32'h0;
        we_d    = grant_1_d & we_1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            rdata_q      <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            done_0_q     <= 1'b0;
            done_1_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_0 || req_1) begin
                        state_q     <= ACCESS;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        owner_q     <= grant_1_d;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        we_q        <= we_d;
                        mem_addr_q  <= addr_d;
                        mem_din_q   <= wdata_d;
                        mem_read_q  <= ~we_d;
                        // A single-cycle access is already its own final cycle.
                        mem_write_q <= we_d && (LATENCY == 1);
                        busy_q      <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q       <= cnt_q - 1'b1;
                        mem_write_q <= we_q && (cnt_q == CNT_W'(1));
                    end else begin
                        state_q     <= RESP;
                        rdata_q     <= we_q ? 32'h0 : mem_dout;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_din_q   <= '0;
                        done_0_q    <= ~owner_q;
                        done_1_q    <= owner_q;
                    end
                end

                RESP: begin
                    state_q  <= IDLE;
                    done_0_q <= 1'b0;
                    done_1_q <= 1'b0;
                    busy_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_owner_q <= owner_q;
`endif
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Reset masks every output in the same cycle, so an aborted store never reaches the memory.
    assign mem_read  = mem_read_q  & ~reset;
    assign mem_write = mem_write_q & ~reset;
    assign mem_addr  = reset ? 32'h0 : mem_addr_q;
    assign mem_din   = reset ? 32'h0 : mem_din_q;
    assign done_0    = done_0_q & ~reset;
    assign done_1    = done_1_q & ~reset;
    assign rdata_0   = done_0 ? rdata_q : 32'h0;
    assign rdata_1   = done_1 ? rdata_q : 32'h0;
    assign busy      = busy_q & ~reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timeline reference model (expected done cycle = grant cycle + LATENCY + 1).
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        load_mem;

    // Instance A: LATENCY = 2
    logic        req_0, req_1, we_1;
    logic [31:0] addr_0, addr_1, wdata_1;
    logic        done_0, done_1;
    logic [31:0] rdata_0, rdata_1;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write, busy;

    // Instance B: LATENCY = 1
    logic        req_0b, req_1b, we_1b;
    logic [31:0] addr_0b, addr_1b, wdata_1b;
    logic        done_0b, done_1b;
    logic [31:0] rdata_0b, rdata_1b;
    logic [31:0] mem_addr_b, mem_din_b, mem_dout_b;
    logic        mem_read_b, mem_write_b, busy_b;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] mem   [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] ref_mem [int];

    mem_arbiter #(.LATENCY(LAT), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .addr_0(addr_0), .done_0(done_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .done_1(done_1), .rdata_1(rdata_1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout), .busy(busy)
    );

    mem_arbiter #(.LATENCY(1), .CNT_W(4)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_0(req_0b), .addr_0(addr_0b), .done_0(done_0b), .rdata_0(rdata_0b),
        .req_1(req_1b), .we_1(we_1b), .addr_1(addr_1b), .wdata_1(wdata_1b),
        .done_1(done_1b), .rdata_1(rdata_1b),
        .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .mem_dout(mem_dout_b), .busy(busy_b)
    );

    function automatic logic [31:0] init_word(int idx);
        if (idx == 'h10) return 32'hDEADBEEF;
        if (idx == 'h30) return 32'h11111111;
        return 32'hA500_0000 ^ (32'(idx) * 32'h0001_0203);
    endfunction

    // Word-addressed memories with asynchronous read, written on the clock edge.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]   <= init_word(i);
                mem_b[i] <= init_word(i);
            end
        end else begin
            if (mem_write)   mem[mem_addr[9:2]]     <= mem_din;
            if (mem_write_b) mem_b[mem_addr_b[9:2]] <= mem_din_b;
        end
    end
    assign mem_dout   = mem[mem_addr[9:2]];
    assign mem_dout_b = mem_b[mem_addr_b[9:2]];

    function automatic logic [132:0] outs_a();
        return {busy, mem_read, mem_write, done_0, done_1, mem_addr, mem_din, rdata_0, rdata_1};
    endfunction

    function automatic logic [132:0] pack(bit b, bit r, bit w, bit d0, bit d1,
                                          logic [31:0] a, logic [31:0] din,
                                          logic [31:0] r0, logic [31:0] r1);
        return {b, r, w, d0, d1, a, din, r0, r1};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_0 = 0; addr_0 = 0; req_1 = 0; we_1 = 0; addr_1 = 0; wdata_1 = 0;
        req_0b = 0; addr_0b = 0; req_1b = 0; we_1b = 0; addr_1b = 0; wdata_1b = 0;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        logic [132:0] obs;
        next_cycle();
        reset = 1;
        req_0 = 1; addr_0 = 32'h40; req_1 = 1; we_1 = 1; addr_1 = 32'h80; wdata_1 = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            obs = outs_a();
            chk_cnt++;
            if (obs !== '0) $display("FAIL reset_outputs cyc%0d: got %h expected 0", k, obs);
            else pass_cnt++;
            next_cycle();
        end
        reset = 0;
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            obs = outs_a();
            chk_cnt++;
            if (obs !== '0) $display("FAIL post_reset_idle cyc%0d: got %h expected 0", k, obs);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_fetch();
        logic [132:0] obs, exp;
        do_reset();
        next_cycle();
        req_0 = 1; addr_0 = 32'h40;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL fetch_busy_T: got %b expected 0", busy);
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 1) addr_0 = 32'h44;   // operands after grant must be ignored
            if (k == 4) req_0 = 0;
            @(negedge clk);
            obs = outs_a();
            exp = pack(k <= 3, k <= 2, 1'b0, k == 3, 1'b0,
                       (k <= 2) ? 32'h40 : 32'h0, 32'h0,
                       (k == 3) ? 32'hDEADBEEF : 32'h0, 32'h0);
            chk_cnt++;
            if (obs !== exp) $display("FAIL fetch_T+%0d: got %h expected %h", k, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_store_load();
        int wr_cnt, wr_at, d_at;
        logic [31:0] rd;
        next_cycle();
        req_1 = 1; we_1 = 1; addr_1 = 32'h80; wdata_1 = 32'h12345678;
        @(negedge clk);
        wr_cnt = 0; wr_at = -1; d_at = -1; rd = 32'hX;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            @(negedge clk);
            if (mem_write) begin wr_cnt++; wr_at = k; end
            if (done_1) begin d_at = k; rd = rdata_1; end
        end
        chk_cnt++;
        if (wr_cnt != 1 || wr_at != 2) $display("FAIL store_write_pulse: got %0d pulses at T+%0d expected 1 at T+2", wr_cnt, wr_at);
        else pass_cnt++;
        chk_cnt++;
        if (d_at != 3 || rd !== 32'h0) $display("FAIL store_done: got T+%0d rdata %h expected T+3 rdata 0", d_at, rd);
        else pass_cnt++;
        chk_cnt++;
        if (mem['h20] !== 32'h12345678) $display("FAIL store_mem: got %h expected 12345678", mem['h20]);
        else pass_cnt++;
        // req_1 stays high in the cycle after done: that is a new access (a load here).
        next_cycle();
        we_1 = 0; wdata_1 = 0;
        @(negedge clk);
        d_at = -1; rd = 32'hX;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 1) addr_1 = 32'h0;
            @(negedge clk);
            if (done_1) begin d_at = k; rd = rdata_1; end
        end
        chk_cnt++;
        if (d_at != 3 || rd !== 32'h12345678) $display("FAIL load_after_store: got T+%0d rdata %h expected T+3 rdata 12345678", d_at, rd);
        else pass_cnt++;
        next_cycle();
        req_1 = 0;
    endtask

    task automatic test_priority();
        int d0, d1, first_w, exp0, exp1;
        logic [31:0] r0, r1;
        bit drop0, drop1;
`ifdef MEM_ARB_RR_EN
        first_w = 0;
`else
        first_w = 1;
`endif
        exp0 = (first_w == 0) ? 3 : 3 + LAT + 2;
        exp1 = (first_w == 1) ? 3 : 3 + LAT + 2;
        do_reset();
        next_cycle();
        req_0 = 1; addr_0 = 32'h40; req_1 = 1; we_1 = 0; addr_1 = 32'h80; wdata_1 = 0;
        @(negedge clk);
        d0 = -1; d1 = -1; drop0 = 0; drop1 = 0; r0 = 32'hX; r1 = 32'hX;
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            if (drop0) begin req_0 = 0; drop0 = 0; end
            if (drop1) begin req_1 = 0; drop1 = 0; end
            @(negedge clk);
            if (done_0) begin if (d0 < 0) begin d0 = k; r0 = rdata_0; end drop0 = 1; end
            if (done_1) begin if (d1 < 0) begin d1 = k; r1 = rdata_1; end drop1 = 1; end
        end
        chk_cnt++;
        if (d0 != exp0) $display("FAIL tie_done0_cycle: got T+%0d expected T+%0d", d0, exp0);
        else pass_cnt++;
        chk_cnt++;
        if (d1 != exp1) $display("FAIL tie_done1_cycle: got T+%0d expected T+%0d", d1, exp1);
        else pass_cnt++;
        chk_cnt++;
        if (r0 !== 32'hDEADBEEF || r1 !== 32'h12345678) $display("FAIL tie_rdata: got %h/%h expected deadbeef/12345678", r0, r1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cnt, exp_port, exp_last;
        int port_seen [4];
        int cyc_seen [4];
        do_reset();
        next_cycle();
        req_0 = 1; addr_0 = 32'h40; req_1 = 1; we_1 = 0; addr_1 = 32'h80;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin port_seen[i] = -1; cyc_seen[i] = -1; end
        for (int k = 1; k <= 18; k++) begin
            next_cycle();
            @(negedge clk);
            if (done_0 || done_1) begin
                if (cnt < 4) begin port_seen[cnt] = int'(done_1); cyc_seen[cnt] = k; end
                cnt++;
            end
        end
        req_0 = 0; req_1 = 0;
        chk_cnt++;
        if (cnt != 4) $display("FAIL b2b_count: got %0d grants expected 4", cnt);
        else pass_cnt++;
        exp_last = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_port = (exp_last == 1) ? 0 : 1;
`else
            exp_port = 1;
`endif
            exp_last = exp_port;
            chk_cnt++;
            if (port_seen[i] != exp_port || cyc_seen[i] != 3 + i * (LAT + 2))
                $display("FAIL b2b_grant%0d: got port %0d at T+%0d expected port %0d at T+%0d",
                         i, port_seen[i], cyc_seen[i], exp_port, 3 + i * (LAT + 2));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_access();
        int bad;
        do_reset();
        next_cycle();
        req_1 = 1; we_1 = 1; addr_1 = 32'hC0; wdata_1 = 32'hCAFEF00D;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b1 || mem_write !== 1'b0) $display("FAIL abort_T+1: got busy %b wr %b expected 1 0", busy, mem_write);
        else pass_cnt++;
        next_cycle();
        reset = 1;
        @(negedge clk);
        chk_cnt++;
        if (outs_a() !== '0) $display("FAIL abort_reset_cycle: got %h expected 0", outs_a());
        else pass_cnt++;
        next_cycle();
        reset = 0; req_1 = 0; we_1 = 0;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL abort_idle_after: got busy %b expected 0", busy);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            if (done_0 || done_1 || mem_write || busy) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (mem['h30] !== 32'h11111111) $display("FAIL abort_mem: got %h expected 11111111", mem['h30]);
        else pass_cnt++;
    endtask

    task automatic test_latency1();
        int d_at;
        logic [31:0] rd;
        do_reset();
        next_cycle();
        req_0b = 1; addr_0b = 32'h40;
        @(negedge clk);
        d_at = -1; rd = 32'hX;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 3) req_0b = 0;
            @(negedge clk);
            if (k == 1) begin
                chk_cnt++;
                if (mem_read_b !== 1'b1 || mem_addr_b !== 32'h40) $display("FAIL l1_access: got rd %b addr %h expected 1 40", mem_read_b, mem_addr_b);
                else pass_cnt++;
            end
            if (done_0b) begin d_at = k; rd = rdata_0b; end
        end
        chk_cnt++;
        if (d_at != 2 || rd !== 32'hDEADBEEF) $display("FAIL l1_load: got T+%0d rdata %h expected T+2 deadbeef", d_at, rd);
        else pass_cnt++;
        // Load on port 1 with req dropped during ACCESS still completes.
        next_cycle();
        req_1b = 1; we_1b = 0; addr_1b = 32'hC0;
        @(negedge clk);
        next_cycle();
        req_1b = 0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if (done_1b !== 1'b1 || rdata_1b !== 32'h11111111) $display("FAIL l1_drop_done: got done %b rdata %h expected 1 11111111", done_1b, rdata_1b);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if (busy_b !== 1'b0 || done_1b !== 1'b0) $display("FAIL l1_drop_idle: got busy %b done %b expected 0 0", busy_b, done_1b);
        else pass_cnt++;
        // Single-cycle store: mem_write in the only ACCESS cycle.
        next_cycle();
        req_1b = 1; we_1b = 1; addr_1b = 32'hC4; wdata_1b = 32'h5555AAAA;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if (mem_write_b !== 1'b1 || mem_read_b !== 1'b0 || mem_din_b !== 32'h5555AAAA)
            $display("FAIL l1_store_cmd: got wr %b rd %b din %h expected 1 0 5555aaaa", mem_write_b, mem_read_b, mem_din_b);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if (done_1b !== 1'b1 || mem_b['h31] !== 32'h5555AAAA) $display("FAIL l1_store_done: got done %b mem %h expected 1 5555aaaa", done_1b, mem_b['h31]);
        else pass_cnt++;
        next_cycle();
        req_1b = 0; we_1b = 0;
    endtask

    task automatic test_random();
        int c, m_g, m_d, idx;
        bit m_valid, m_port, m_we, m_last, win, in_acc;
        logic [31:0] m_addr, m_wdata, e_rdata;
        logic [132:0] obs, exp;
        bit pend [2];
        bit seen_done [2];
        int idle [2];
        do_reset();
        m_valid = 0; m_last = 1; m_port = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_g = 0; m_d = 0;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; seen_done[p] = 0; idle[p] = 0; end
        c = 0;
        for (int n = 0; n < 600; n++) begin
            next_cycle();
            for (int p = 0; p < 2; p++) begin
                if (seen_done[p]) begin
                    seen_done[p] = 0; pend[p] = 0; idle[p] = $urandom_range(0, 3);
                    if (p == 0) req_0 = 0; else req_1 = 0;
                end else if (!pend[p]) begin
                    if (idle[p] > 0) idle[p]--;
                    else if ($urandom_range(0, 1) == 1) begin
                        pend[p] = 1;
                        if (p == 0) begin
                            req_0 = 1; addr_0 = 32'h100 + 32'($urandom_range(0, 15)) * 4;
                        end else begin
                            req_1 = 1; we_1 = 1'($urandom_range(0, 1));
                            addr_1 = 32'h100 + 32'($urandom_range(0, 15)) * 4; wdata_1 = $urandom;
                        end
                    end
                end else if (m_valid && int'(m_port) == p && c > m_g) begin
                    if ($urandom_range(0, 7) == 0) begin
                        if (p == 0) req_0 = 0; else req_1 = 0;
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        if (p == 0) addr_0 = $urandom;
                        else begin addr_1 = $urandom; wdata_1 = $urandom; we_1 = ~we_1; end
                    end
                end
            end
            @(negedge clk);
            in_acc = m_valid && c > m_g && c < m_d;
            idx = int'(m_addr[9:2]);
            e_rdata = m_we ? 32'h0 : (ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx));
            exp = pack(m_valid && c > m_g && c <= m_d, in_acc && !m_we,
                       m_valid && m_we && c == m_d - 1,
                       m_valid && c == m_d && !m_port, m_valid && c == m_d && m_port,
                       in_acc ? m_addr : 32'h0, in_acc ? m_wdata : 32'h0,
                       (m_valid && c == m_d && !m_port) ? e_rdata : 32'h0,
                       (m_valid && c == m_d && m_port) ? e_rdata : 32'h0);
            obs = outs_a();
            chk_cnt++;
            if (obs !== exp) $display("FAIL rand_outputs cyc%0d: got %h expected %h", c, obs, exp);
            else pass_cnt++;
            if (m_valid && m_we && c == m_d - 1) ref_mem[idx] = m_wdata;
            if (m_valid && c == m_d) begin
                m_valid = 0; m_last = m_port; seen_done[m_port] = 1;
            end else if (!m_valid && (req_0 || req_1)) begin
`ifdef MEM_ARB_RR_EN
                win = (req_0 && req_1) ? ~m_last : req_1;
`else
                win = req_1;
`endif
                m_valid = 1; m_port = win; m_we = win ? we_1 : 1'b0;
                m_addr = win ? addr_1 : addr_0; m_wdata = win ? wdata_1 : 32'h0;
                m_g = c; m_d = c + LAT + 1;
            end
            c++;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        load_mem = 1;
        @(posedge clk);
        #1;
        load_mem = 0;
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_back_to_back();
        test_reset_mid_access();
        test_latency1();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
